c128_ram_arbiter: RTL

- Shares the single system-RAM port between three requesters: VIC-II fetches, DMA/REU, and the CPU (8502/Z80 via MMU-translated bank+address).
- Fixed priority VIC > DMA > CPU, with a starvation guard that lifts the CPU above DMA.
- Also issues periodic refresh and returns read data to the issuing requester after a fixed RAM latency.
- Sits between the MMU/VIC/DMA address outputs and the RAM controller.

---
 rtl/c128_ram_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/c128_ram_arbiter.sv
// System-RAM port arbiter for VIC-II, DMA/REU and CPU with periodic refresh.
// Registered grant/command outputs; read data is routed back to its issuer after RD_LAT.
module c128_ram_arbiter #(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned STARVE_MAX   = 4,
  parameter int unsigned REF_INTERVAL = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sys256k,
  // VIC-II (read-only)
  input  logic        vic_req,
  input  logic [17:0] vic_addr,
  output logic        vic_ack,
  output logic        vic_rvalid,
  // DMA / REU
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [17:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic        dma_rvalid,
  // CPU via MMU
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [17:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  // Shared read return
  output logic [7:0]  rdata,
  // RAM controller side
  input  logic        ram_ready,
  output logic        ram_ce,
  output logic        ram_we,
  output logic        ram_refresh,
  output logic [17:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  localparam int unsigned AW  = 18;
  localparam int unsigned SCW = $clog2(STARVE_MAX + 1);
  localparam int unsigned RCW = $clog2(REF_INTERVAL);
  localparam int unsigned PW  = 3;

  localparam logic [1:0] OWN_VIC = 2'd0;
  localparam logic [1:0] OWN_DMA = 2'd1;
  localparam logic [1:0] OWN_CPU = 2'd2;

  // 128k machines have no second RAM bank pair: bank bit 1 is forced low.
  function automatic logic [AW-1:0] mask_addr(input logic [AW-1:0] a, input logic big);
    return {a[AW-1] & big, a[AW-2:0]};
  endfunction

  logic [SCW-1:0] r_starve;
  logic [RCW-1:0] r_ref_cnt;
  logic           r_ref_pend;
  logic [PW-1:0]  r_pipe [RD_LAT];

  logic           w_vic_elig;
  logic           w_dma_elig;
  logic           w_cpu_elig;
  logic           w_cpu_promo;
  logic           w_g_vic;
  logic           w_g_ref;
  logic           w_g_dma;
  logic           w_g_cpu;
  logic           w_issue_rd;
  logic [1:0]     w_issue_own;
  logic [PW-1:0]  w_head;
  logic           w_ref_wrap;

  // Eligibility: a requester acked this cycle must present a fresh request first.
  always_comb begin
    w_vic_elig  = vic_req & ~vic_ack;
    w_dma_elig  = dma_req & ~dma_ack;
    w_cpu_elig  = cpu_req & ~cpu_ack;
    w_cpu_promo = w_cpu_elig && (r_starve == SCW'(STARVE_MAX));
  end

  // Priority select: VIC > refresh > starved CPU > DMA > CPU.
  always_comb begin
    w_g_vic = 1'b0;
    w_g_ref = 1'b0;
    w_g_dma = 1'b0;
    w_g_cpu = 1'b0;
    if (ram_ready) begin
      if (w_vic_elig)       w_g_vic = 1'b1;
      else if (r_ref_pend)  w_g_ref = 1'b1;
      else if (w_cpu_promo) w_g_cpu = 1'b1;
      else if (w_dma_elig)  w_g_dma = 1'b1;
      else if (w_cpu_elig)  w_g_cpu = 1'b1;
    end
  end

  // The command currently on the RAM port feeds the return pipeline.
  always_comb begin
    w_issue_rd  = ram_ce & ~ram_we;
    w_issue_own = OWN_VIC;
    if (dma_ack)      w_issue_own = OWN_DMA;
    else if (cpu_ack) w_issue_own = OWN_CPU;
    w_head     = r_pipe[RD_LAT-1];
    w_ref_wrap = (r_ref_cnt == RCW'(REF_INTERVAL - 1));
  end

  // Command issue and grant pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      vic_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      ram_ce      <= 1'b0;
      ram_we      <= 1'b0;
      ram_refresh <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      vic_ack     <= w_g_vic;
      dma_ack     <= w_g_dma;
      cpu_ack     <= w_g_cpu;
      ram_ce      <= w_g_vic | w_g_dma | w_g_cpu;
      ram_we      <= (w_g_dma & dma_we) | (w_g_cpu & cpu_we);
      ram_refresh <= w_g_ref;
      if (w_g_vic) begin
        ram_addr <= mask_addr(vic_addr, sys256k);
      end else if (w_g_dma) begin
        ram_addr <= mask_addr(dma_addr, sys256k);
        ram_din  <= dma_wdata;
      end else if (w_g_cpu) begin
        ram_addr <= mask_addr(cpu_addr, sys256k);
        ram_din  <= cpu_wdata;
      end
    end
  end

  // CPU starvation counter: only DMA wins over an eligible CPU count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_g_cpu) begin
      r_starve <= '0;
    end else if (w_g_dma && w_cpu_elig && (r_starve != SCW'(STARVE_MAX))) begin
      r_starve <= r_starve + SCW'(1);
    end
  end

  // Refresh timer; a wrap coinciding with an issue re-arms so no interval is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else if (w_ref_wrap) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b1;
    end else begin
      r_ref_cnt <= r_ref_cnt + RCW'(1);
      if (w_g_ref) r_ref_pend <= 1'b0;
    end
  end

  // Read return: {valid, owner} travels RD_LAT stages alongside the RAM access.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
      vic_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      rdata      <= '0;
    end else begin
      r_pipe[0] <= {w_issue_rd, w_issue_own};
      for (int unsigned i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      vic_rvalid <= w_head[2] && (w_head[1:0] == OWN_VIC);
      dma_rvalid <= w_head[2] && (w_head[1:0] == OWN_DMA);
      cpu_rvalid <= w_head[2] && (w_head[1:0] == OWN_CPU);
      if (w_head[2]) rdata <= ram_dout;
    end
  end

endmodule
